// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS memory-access stage.
//   state_t      : FSM states of the memory-access controller
//   WB_REGWRITE  : bit index of RegWrite inside the 2-bit WB control field
//   WB_MEMTOREG  : bit index of MemtoReg inside the 2-bit WB control field
//   DEF_TIMEOUT  : default REQ-cycle limit before an access is aborted
//   DEF_CNT_W    : default timeout counter width (2**DEF_CNT_W > DEF_TIMEOUT)
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  localparam int DEF_TIMEOUT = 16;
  localparam int DEF_CNT_W   = 5;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus.
//   mem_req   : request, held high for the whole transaction
//   mem_we    : write enable, valid while mem_req = 1
//   mem_addr  : byte address, stable while mem_req = 1
//   mem_wdata : store data, stable while mem_req = 1
//   mem_ack   : single-cycle completion pulse from memory
//   mem_rdata : load data, valid only in the cycle mem_ack = 1
//
// Handshake: the master raises mem_req with stable mem_we/mem_addr/mem_wdata
// and keeps them unchanged until it sees mem_ack = 1 on a rising edge (or it
// gives up); mem_req drops on that same edge. mem_ack is only meaningful
// while mem_req = 1 and is ignored otherwise. A request may be abandoned by
// reset, so the slave must tolerate mem_req dropping without an ack.
interface mem_access_stage_if;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/mem_access_stage_mem_wb_reg.sv
// MEM/WB pipeline register. Loads every cycle; when bubble_i is set it loads
// all zeros instead of the inputs.
//   clk_i, rst_i (async active-low)
//   bubble_i                : load a bubble instead of the inputs
//   WB_i/ReadData_i/ALU_i/RdAddr_i : next MEM/WB contents
//   WB_o/ReadData_o/ALU_o/RdAddr_o : registered MEM/WB contents
module mem_wb_reg (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        bubble_i,
  input  logic [1:0]  WB_i,
  input  logic [31:0] ReadData_i,
  input  logic [31:0] ALU_i,
  input  logic [4:0]  RdAddr_i,
  output logic [1:0]  WB_o,
  output logic [31:0] ReadData_o,
  output logic [31:0] ALU_o,
  output logic [4:0]  RdAddr_o
);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      WB_o       <= '0;
      ReadData_o <= '0;
      ALU_o      <= '0;
      RdAddr_o   <= '0;
    end else if (bubble_i) begin
      WB_o       <= '0;
      ReadData_o <= '0;
      ALU_o      <= '0;
      RdAddr_o   <= '0;
    end else begin
      WB_o       <= WB_i;
      ReadData_o <= ReadData_i;
      ALU_o      <= ALU_i;
      RdAddr_o   <= RdAddr_i;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MIPS memory-access stage. Runs a registered request/ack transaction with a
// variable-latency data memory for loads/stores, stalls upstream while it is
// in flight, aborts after TIMEOUT REQ cycles, and feeds the MEM/WB register.
//   clk_i, rst_i (async active-low)
//   WB_i, MemRead_i, MemWrite_i, ALU_i, WriteData_i, RdAddr_i : from EX/MEM
//   mem (master)  : data-memory request/ack bus
//   stall_o       : freezes PC, IF/ID, ID/EX, EX/MEM
//   err_o         : sticky timeout flag, cleared only by reset
//   WB_o, ReadData_o, ALU_o, RdAddr_o : MEM/WB register outputs
//   dbg_state_o   : current controller state
module mem_access_stage
  import mips_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = DEF_CNT_W   // 2**CNT_W must exceed TIMEOUT
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [1:0]          WB_i,
  input  logic                MemRead_i,
  input  logic                MemWrite_i,
  input  logic [31:0]         ALU_i,
  input  logic [31:0]         WriteData_i,
  input  logic [4:0]          RdAddr_i,
  mem_access_stage_if.master  mem,
  output logic                stall_o,
  output logic                err_o,
  output logic [1:0]          WB_o,
  output logic [31:0]         ReadData_o,
  output logic [31:0]         ALU_o,
  output logic [4:0]          RdAddr_o,
  output state_t              dbg_state_o
);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_err;
  logic               r_req;
  logic               r_we;
  logic [31:0]        r_addr;
  logic [31:0]        r_wdata;
  logic [31:0]        r_rbuf;

  logic               w_mem_op;
  logic               w_stall;
  logic [31:0]        w_rdata_in;

  assign w_mem_op = MemRead_i | MemWrite_i;

  // Gated by reset so that nothing upstream is frozen while the stage is held.
  assign w_stall = rst_i && ((r_state == REQ) || ((r_state == IDLE) && w_mem_op));

  // Only DONE forwards the captured read data; a plain ALU op writes back 0.
  assign w_rdata_in = (r_state == DONE) ? r_rbuf : 32'd0;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rbuf  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_mem_op) begin
            r_req   <= 1'b1;
            r_we    <= MemWrite_i;   // both bits set means store
            r_addr  <= ALU_i;
            r_wdata <= WriteData_i;
            r_cnt   <= '0;
            r_state <= REQ;
          end
        end
        REQ: begin
          if (mem.mem_ack) begin
            r_req   <= 1'b0;
            r_rbuf  <= r_we ? 32'd0 : mem.mem_rdata;
            r_state <= DONE;
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_req   <= 1'b0;
            r_err   <= 1'b1;
            r_rbuf  <= 32'd0;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  mem_wb_reg u_mem_wb_reg (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .bubble_i   (w_stall),
    .WB_i       (WB_i),
    .ReadData_i (w_rdata_in),
    .ALU_i      (ALU_i),
    .RdAddr_i   (RdAddr_i),
    .WB_o       (WB_o),
    .ReadData_o (ReadData_o),
    .ALU_o      (ALU_o),
    .RdAddr_o   (RdAddr_o)
  );

  assign mem.mem_req   = r_req;
  assign mem.mem_we    = r_we;
  assign mem.mem_addr  = r_addr;
  assign mem.mem_wdata = r_wdata;
  assign stall_o       = w_stall;
  assign err_o         = r_err;
  assign dbg_state_o   = r_state;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
  import mips_pkg::*;

  localparam int TIMEOUT = DEF_TIMEOUT;

  // ---------------- clock / reset ----------------
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [1:0]  WB_i = '0;
  logic        MemRead_i = 1'b0;
  logic        MemWrite_i = 1'b0;
  logic [31:0] ALU_i = '0;
  logic [31:0] WriteData_i = '0;
  logic [4:0]  RdAddr_i = '0;
  logic        stall_o;
  logic        err_o;
  logic [1:0]  WB_o;
  logic [31:0] ReadData_o;
  logic [31:0] ALU_o;
  logic [4:0]  RdAddr_o;
  state_t      dbg_state;

  mem_access_stage_if mem ();

  always #5 clk_i = ~clk_i;

  mem_access_stage #(.TIMEOUT(TIMEOUT), .CNT_W(DEF_CNT_W)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .WB_i        (WB_i),
    .MemRead_i   (MemRead_i),
    .MemWrite_i  (MemWrite_i),
    .ALU_i       (ALU_i),
    .WriteData_i (WriteData_i),
    .RdAddr_i    (RdAddr_i),
    .mem         (mem.master),
    .stall_o     (stall_o),
    .err_o       (err_o),
    .WB_o        (WB_o),
    .ReadData_o  (ReadData_o),
    .ALU_o       (ALU_o),
    .RdAddr_o    (RdAddr_o),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic        exp_err = 1'b0;
  logic [70:0] exp_q[$];   // {WB, ReadData, ALU, RdAddr}

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  wb;
    logic        rd;
    logic        wr;
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [4:0]  rdaddr;
    int          lat;        // REQ cycle index (0-based) carrying the ack; -1 = never
    logic [31:0] rdata;
    logic [31:0] exp_rdata;
    int          exp_stalls;
  } vec_t;

  // ---------------- driver ----------------
  // Called at a falling edge. Drives one EX/MEM instruction, plays the memory
  // side, and checks the bus, stall count and MEM/WB result.
  task automatic run_op(input logic [1:0] wb, input logic rd, input logic wr,
                        input logic [31:0] alu, input logic [31:0] wdata,
                        input logic [4:0] rdaddr, input int lat,
                        input logic [31:0] rdata, input int exp_stalls,
                        input bit stray);
    int cyc;
    int stalls;
    int reqs;
    bit done;
    logic s;
    logic rq;
    logic [70:0] exp;
    cyc = 0; stalls = 0; reqs = 0; done = 0;
    WB_i = wb; MemRead_i = rd; MemWrite_i = wr; ALU_i = alu;
    WriteData_i = wdata; RdAddr_i = rdaddr;
    while (!done && cyc < 64) begin
      #1;
      s  = stall_o;
      rq = mem.mem_req;
      if (rq) begin
        check("req_addr", 72'(mem.mem_addr), 72'(alu));
        check("req_we", 72'(mem.mem_we), 72'(wr));
        check("req_wdata", 72'(mem.mem_wdata), 72'(wdata));
        if (reqs == lat) begin
          mem.mem_ack = 1'b1; mem.mem_rdata = rdata;
        end else begin
          mem.mem_ack = 1'b0; mem.mem_rdata = $urandom;
        end
        reqs++;
      end else begin
        mem.mem_ack   = stray ? 1'($urandom_range(0, 1)) : 1'b0;
        mem.mem_rdata = $urandom;
      end
      if (s) stalls++;
      @(posedge clk_i);
      #1;
      if (s) check("bubble", 72'({WB_o, ReadData_o, ALU_o, RdAddr_o}), 72'd0);
      else done = 1;
      cyc++;
      @(negedge clk_i);
      mem.mem_ack = 1'b0;
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL op_budget: stall still high after %0d cycles, required release", cyc);
    end
    check("stall_cycles", 72'(stalls), 72'(exp_stalls));
    check("req_cycles", 72'(reqs), 72'(exp_stalls > 0 ? exp_stalls - 1 : 0));
    exp = exp_q.pop_front();
    check("mem_wb", 72'({WB_o, ReadData_o, ALU_o, RdAddr_o}), 72'(exp));
    check("err", 72'(err_o), 72'(exp_err));
  endtask

  // ---------------- test ----------------
  vec_t vecs[5];

  initial begin
    vecs[0] = '{2'b10, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 5'd5, -1, 32'h0, 32'h0, 0};
    vecs[1] = '{2'b11, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 5'd8, 2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4};
    vecs[2] = '{2'b00, 1'b0, 1'b1, 32'h0000_0200, 32'h1234_5678, 5'd0, 0, 32'h0, 32'h0, 2};
    vecs[3] = '{2'b00, 1'b1, 1'b1, 32'h0000_0204, 32'hA5A5_0001, 5'd3, 1, 32'hAAAA_5555, 32'h0, 3};
    vecs[4] = '{2'b11, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 5'd31, 0, 32'h0000_5555, 32'h0000_5555, 2};

    mem.mem_ack = 1'b0;
    mem.mem_rdata = '0;

    // Reset with random inputs.
    rst_i = 1'b0;
    repeat (3) begin
      @(negedge clk_i);
      WB_i = 2'($urandom); MemRead_i = 1'($urandom); MemWrite_i = 1'($urandom);
      ALU_i = $urandom; WriteData_i = $urandom; RdAddr_i = 5'($urandom);
      mem.mem_ack = 1'($urandom);
    end
    #1;
    check("rst_outputs", 72'({WB_o, ReadData_o, ALU_o, RdAddr_o}), 72'd0);
    check("rst_bus", 72'({mem.mem_req, mem.mem_we, mem.mem_addr, mem.mem_wdata}), 72'd0);
    check("rst_stall_err", 72'({stall_o, err_o}), 72'd0);
    @(negedge clk_i);
    WB_i = '0; MemRead_i = 0; MemWrite_i = 0; mem.mem_ack = 0;
    rst_i = 1'b1;
    #1;
    check("rst_state", 72'(dbg_state), 72'(IDLE));
    @(negedge clk_i);

    // Directed vector table.
    foreach (vecs[i]) begin
      exp_q.push_back({vecs[i].wb, vecs[i].exp_rdata, vecs[i].alu, vecs[i].rdaddr});
      run_op(vecs[i].wb, vecs[i].rd, vecs[i].wr, vecs[i].alu, vecs[i].wdata,
             vecs[i].rdaddr, vecs[i].lat, vecs[i].rdata, vecs[i].exp_stalls, 1'b0);
    end

    // Random ops against a latency/result model.
    for (int n = 0; n < 40; n++) begin
      logic [1:0]  wb;
      logic        rd;
      logic        wr;
      logic [31:0] alu;
      logic [31:0] wd;
      logic [31:0] rdat;
      logic [4:0]  ra;
      int          lat;
      bit          is_mem;
      bit          to;
      int          stalls;
      logic [31:0] erd;
      wb = 2'($urandom); rd = 1'($urandom); wr = 1'($urandom);
      alu = $urandom; wd = $urandom; rdat = $urandom; ra = 5'($urandom);
      lat = $urandom_range(0, 19);
      is_mem = rd | wr;
      to     = is_mem && (lat >= TIMEOUT);
      stalls = !is_mem ? 0 : ((to ? TIMEOUT : lat + 1) + 1);
      erd    = (is_mem && rd && !wr && !to) ? rdat : 32'd0;
      if (to) exp_err = 1'b1;
      exp_q.push_back({wb, erd, alu, ra});
      run_op(wb, rd, wr, alu, wd, ra, lat, rdat, stalls, 1'b1);
    end

    // Timeout: load with no ack, then the pipeline resumes with err held.
    exp_err = 1'b1;
    exp_q.push_back({2'b11, 32'd0, 32'h0000_0400, 5'd7});
    run_op(2'b11, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 5'd7, -1, 32'h0, TIMEOUT + 1, 1'b0);
    exp_q.push_back({2'b10, 32'd0, 32'h0000_0044, 5'd9});
    run_op(2'b10, 1'b0, 1'b0, 32'h0000_0044, 32'h0, 5'd9, -1, 32'h0, 0, 1'b0);

    // Reset during the second REQ cycle, then a stray ack in IDLE.
    WB_i = 2'b11; MemRead_i = 1'b1; MemWrite_i = 1'b0; ALU_i = 32'h0000_0300; RdAddr_i = 5'd4;
    @(posedge clk_i);
    @(negedge clk_i);
    @(posedge clk_i);
    @(negedge clk_i);
    #1;
    check("midreq_req_before", 72'(mem.mem_req), 72'd1);
    rst_i = 1'b0;
    #1;
    check("midreq_req_drop", 72'(mem.mem_req), 72'd0);
    check("midreq_stall_err", 72'({stall_o, err_o}), 72'd0);
    check("midreq_state", 72'(dbg_state), 72'(IDLE));
    @(negedge clk_i);
    MemRead_i = 1'b0; WB_i = 2'b10; ALU_i = 32'h0000_0055; RdAddr_i = 5'd2;
    rst_i = 1'b1;
    exp_err = 1'b0;
    #1;
    mem.mem_ack = 1'b1; mem.mem_rdata = 32'h0BAD_0BAD;
    @(posedge clk_i);
    #1;
    check("stray_req", 72'(mem.mem_req), 72'd0);
    check("stray_state", 72'(dbg_state), 72'(IDLE));
    check("stray_mem_wb", 72'({WB_o, ReadData_o, ALU_o, RdAddr_o}),
          72'({2'b10, 32'd0, 32'h0000_0055, 5'd2}));
    check("stray_err", 72'(err_o), 72'd0);
    @(negedge clk_i);
    mem.mem_ack = 1'b0;
    exp_q.push_back({2'b11, 32'hCAFE_F00D, 32'h0000_0500, 5'd6});
    run_op(2'b11, 1'b1, 1'b0, 32'h0000_0500, 32'h0, 5'd6, 1, 32'hCAFE_F00D, 3, 1'b0);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
